// File: rtl/vga_sync_rx.sv
// VGA sync receiver: synchronizes HS/VS, measures line/sync/frame timing, regenerates
// H/V position counters and tracks lock against the expected raster.
module vga_sync_rx #(
    parameter int unsigned H_TOTAL_EXP = 800,
    parameter int unsigned V_TOTAL_EXP = 525,
    parameter int unsigned H_TOL       = 2,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned CW          = 12
) (
    input  logic          PIXELCLK,
    input  logic          i_rstn,
    input  logic          VGA_HS,
    input  logic          VGA_VS,
    output logic [9:0]    o_h_cnt,
    output logic [9:0]    o_v_cnt,
    output logic [CW-1:0] o_h_total,
    output logic [CW-1:0] o_hs_width,
    output logic [9:0]    o_v_total,
    output logic          o_locked,
    output logic          o_err
);

    localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] HMax = {CW{1'b1}};
    localparam logic [CW-1:0] HNearMax = {{(CW-1){1'b1}}, 1'b0};
    localparam logic [9:0] CntMax = 10'h3ff;
    localparam int unsigned HiLim = H_TOTAL_EXP + H_TOL;
    localparam int unsigned LoLim = (H_TOTAL_EXP > H_TOL) ? H_TOTAL_EXP - H_TOL : 0;

    typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

    logic          hs_s1_q, hs_s2_q, hs_d_q;
    logic          vs_s1_q, vs_s2_q, vs_d_q;
    logic [CW-1:0] h_run_q, h_run_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [CW-1:0] h_total_q, h_total_d;
    logic [CW-1:0] hsw_cnt_q, hsw_cnt_d;
    logic [CW-1:0] hs_width_q, hs_width_d;
    logic [9:0]    v_run_q, v_run_d;
    logic [9:0]    v_total_q, v_total_d;
    logic          h_valid_q, h_valid_d;
    logic          frame_bad_q, frame_bad_d;
    state_e        state_q, state_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;

    logic          hs_fall, hs_rise, vs_fall;
    logic          line_bad, frame_ok, los;
    int unsigned   line_len;
    logic [CW-1:0] h_len_sat;
    logic [9:0]    v_total_new;
    logic [GW-1:0] good_next;

    always_comb begin
        hs_fall     = hs_d_q & ~hs_s2_q;
        hs_rise     = ~hs_d_q & hs_s2_q;
        vs_fall     = vs_d_q & ~vs_s2_q;
        line_len    = 32'(h_run_q) + 32'd1;
        h_len_sat   = (h_run_q == HMax) ? HMax : h_run_q + CW'(1);
        line_bad    = hs_fall & h_valid_q & ((line_len > HiLim) | (line_len < LoLim));
        // A line closing on the same cycle as VS belongs to the frame that is ending.
        v_total_new = (hs_fall && v_run_q != CntMax) ? v_run_q + 10'd1 : v_run_q;
        frame_ok    = ~(frame_bad_q | line_bad) & (32'(v_total_new) == V_TOTAL_EXP);
        // Fires only on the transition into saturation, so a dead input reports once.
        los         = ~hs_fall & (h_run_q == HNearMax);
        good_next   = good_cnt_q + GW'(1);

        h_run_d    = hs_fall ? '0 : ((h_run_q == HMax) ? HMax : h_run_q + CW'(1));
        h_total_d  = hs_fall ? h_len_sat : h_total_q;
        h_cnt_d    = hs_fall ? '0 : ((h_cnt_q == CntMax) ? CntMax : h_cnt_q + 10'd1);
        hs_width_d = hs_rise ? hsw_cnt_q : hs_width_q;
        if (hs_fall) begin
            hsw_cnt_d = CW'(1);
        end else if (!hs_s2_q && hsw_cnt_q != HMax) begin
            hsw_cnt_d = hsw_cnt_q + CW'(1);
        end else begin
            hsw_cnt_d = hsw_cnt_q;
        end

        if (vs_fall) begin
            v_run_d = '0;
        end else if (hs_fall && v_run_q != CntMax) begin
            v_run_d = v_run_q + 10'd1;
        end else begin
            v_run_d = v_run_q;
        end
        v_total_d   = vs_fall ? v_total_new : v_total_q;
        h_valid_d   = h_valid_q | hs_fall;
        frame_bad_d = vs_fall ? 1'b0 : (frame_bad_q | line_bad);

        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        locked_d   = locked_q;
        err_d      = 1'b0;

        if (los) begin
            state_d     = StSearch;
            good_cnt_d  = '0;
            h_valid_d   = 1'b0;
            frame_bad_d = 1'b0;
            locked_d    = 1'b0;
            err_d       = (state_q == StLocked);
        end else begin
            unique case (state_q)
                StSearch: begin
                    if (vs_fall) begin
                        state_d    = StCheck;
                        good_cnt_d = '0;
                    end
                end
                StCheck: begin
                    if (vs_fall) begin
                        if (frame_ok) begin
                            good_cnt_d = good_next;
                            if (32'(good_next) >= LOCK_FRAMES) begin
                                state_d    = StLocked;
                                locked_d   = 1'b1;
                                good_cnt_d = '0;
                            end
                        end else begin
                            good_cnt_d = '0;
                        end
                    end
                end
                StLocked: begin
                    if (line_bad || (vs_fall && !frame_ok)) begin
                        err_d      = 1'b1;
                        locked_d   = 1'b0;
                        state_d    = StCheck;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = StSearch;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge PIXELCLK or negedge i_rstn) begin
        if (!i_rstn) begin
            hs_s1_q     <= 1'b1;
            hs_s2_q     <= 1'b1;
            hs_d_q      <= 1'b1;
            vs_s1_q     <= 1'b1;
            vs_s2_q     <= 1'b1;
            vs_d_q      <= 1'b1;
            h_run_q     <= '0;
            h_cnt_q     <= '0;
            h_total_q   <= '0;
            hsw_cnt_q   <= '0;
            hs_width_q  <= '0;
            v_run_q     <= '0;
            v_total_q   <= '0;
            h_valid_q   <= 1'b0;
            frame_bad_q <= 1'b0;
            state_q     <= StSearch;
            good_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            hs_s1_q     <= VGA_HS;
            hs_s2_q     <= hs_s1_q;
            hs_d_q      <= hs_s2_q;
            vs_s1_q     <= VGA_VS;
            vs_s2_q     <= vs_s1_q;
            vs_d_q      <= vs_s2_q;
            h_run_q     <= h_run_d;
            h_cnt_q     <= h_cnt_d;
            h_total_q   <= h_total_d;
            hsw_cnt_q   <= hsw_cnt_d;
            hs_width_q  <= hs_width_d;
            v_run_q     <= v_run_d;
            v_total_q   <= v_total_d;
            h_valid_q   <= h_valid_d;
            frame_bad_q <= frame_bad_d;
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign o_h_cnt    = h_cnt_q;
    assign o_v_cnt    = v_run_q;
    assign o_h_total  = h_total_q;
    assign o_hs_width = hs_width_q;
    assign o_v_total  = v_total_q;
    assign o_locked   = locked_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a shrunken 40x12 raster (HS low 5 cycles, VS low 3 lines,
// VS falling together with HS).
module tb_vga_sync_rx;

    localparam int HT     = 40;
    localparam int VT     = 12;
    localparam int HS_LOW = 5;

    logic        PIXELCLK = 1'b0;
    logic        i_rstn;
    logic        VGA_HS;
    logic        VGA_VS;
    logic [9:0]  o_h_cnt;
    logic [9:0]  o_v_cnt;
    logic [11:0] o_h_total;
    logic [11:0] o_hs_width;
    logic [9:0]  o_v_total;
    logic        o_locked;
    logic        o_err;

    int n_checks = 0;
    int n_errors = 0;
    int err_pulses = 0;

    vga_sync_rx #(
        .H_TOTAL_EXP(HT),
        .V_TOTAL_EXP(VT),
        .H_TOL      (2),
        .LOCK_FRAMES(2),
        .CW         (12)
    ) u_dut (
        .PIXELCLK  (PIXELCLK),
        .i_rstn    (i_rstn),
        .VGA_HS    (VGA_HS),
        .VGA_VS    (VGA_VS),
        .o_h_cnt   (o_h_cnt),
        .o_v_cnt   (o_v_cnt),
        .o_h_total (o_h_total),
        .o_hs_width(o_hs_width),
        .o_v_total (o_v_total),
        .o_locked  (o_locked),
        .o_err     (o_err)
    );

    always #5 PIXELCLK = ~PIXELCLK;

    always @(negedge PIXELCLK) if (o_err === 1'b1) err_pulses++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic hs, input logic vs);
        @(posedge PIXELCLK);
        #1;
        VGA_HS = hs;
        VGA_VS = vs;
    endtask

    task automatic run_px(input int from, input int to, input logic vs);
        for (int i = from; i < to; i++) pix((i < HS_LOW) ? 1'b0 : 1'b1, vs);
    endtask

    // Remainder of a frame whose line 0 has already been driven up to pixel 'from'.
    task automatic frame_rest(input int nlines, input int from);
        for (int l = 0; l < nlines; l++) run_px((l == 0) ? from : 0, HT, (l < 3) ? 1'b0 : 1'b1);
    endtask

    // First 4 pixels of a frame; checks the vs_fall cycle and the cycle after it.
    task automatic head(input string tag, input int lock_pre, input int lock_post,
                        input int exp_vtot, input int exp_vcnt_pre);
        run_px(0, 3, 1'b0);
        @(negedge PIXELCLK);
        chk({tag, "_lock_pre"}, int'(o_locked), lock_pre);
        chk({tag, "_vcnt_pre"}, int'(o_v_cnt), exp_vcnt_pre);
        run_px(3, 4, 1'b0);
        @(negedge PIXELCLK);
        chk({tag, "_lock_post"}, int'(o_locked), lock_post);
        chk({tag, "_vcnt_post"}, int'(o_v_cnt), 0);
        chk({tag, "_hcnt_post"}, int'(o_h_cnt), 0);
        chk({tag, "_vtot"}, int'(o_v_total), exp_vtot);
    endtask

    initial begin
        int base;
        int found;

        i_rstn = 1'b0;
        VGA_HS = 1'b1;
        VGA_VS = 1'b1;
        repeat (3) @(negedge PIXELCLK);
        chk("rst_hcnt", int'(o_h_cnt), 0);
        chk("rst_vcnt", int'(o_v_cnt), 0);
        chk("rst_htot", int'(o_h_total), 0);
        chk("rst_hsw", int'(o_hs_width), 0);
        chk("rst_vtot", int'(o_v_total), 0);
        chk("rst_lock", int'(o_locked), 0);
        chk("rst_err", int'(o_err), 0);
        i_rstn = 1'b1;
        repeat (2) @(negedge PIXELCLK);

        // Nominal lock: partial first frame, then two good frames.
        base = err_pulses;
        head("nom0", 0, 0, 1, 0);
        frame_rest(VT, 4);
        head("nom1", 0, 0, VT, VT - 1);
        frame_rest(VT, 4);
        head("nom2", 0, 1, VT, VT - 1);
        chk("nom_htot", int'(o_h_total), HT);
        chk("nom_hsw", int'(o_hs_width), HS_LOW);
        chk("nom_err", err_pulses - base, 0);

        // Tolerance: a 42-cycle line is fine, a 43-cycle line breaks lock.
        run_px(4, HT, 1'b0);
        run_px(0, HT, 1'b0);
        run_px(0, HT, 1'b0);
        run_px(0, HT, 1'b1);
        run_px(0, HT, 1'b1);
        run_px(0, HT + 2, 1'b1);
        run_px(0, 4, 1'b1);
        @(negedge PIXELCLK);
        chk("tol42_htot", int'(o_h_total), HT + 2);
        chk("tol42_lock", int'(o_locked), 1);
        chk("tol42_err", err_pulses - base, 0);
        run_px(4, HT, 1'b1);
        run_px(0, HT + 3, 1'b1);
        run_px(0, 4, 1'b1);
        @(negedge PIXELCLK);
        chk("tol43_htot", int'(o_h_total), HT + 3);
        chk("tol43_err", int'(o_err), 1);
        chk("tol43_lock", int'(o_locked), 0);
        run_px(4, 5, 1'b1);
        @(negedge PIXELCLK);
        chk("tol43_err_end", int'(o_err), 0);
        run_px(5, HT, 1'b1);
        for (int l = 9; l < VT; l++) run_px(0, HT, 1'b1);
        head("relk0", 0, 0, VT, VT - 1);
        frame_rest(VT, 4);
        head("relk1", 0, 0, VT, VT - 1);
        frame_rest(VT, 4);
        head("relk2", 0, 1, VT, VT - 1);
        chk("tol_err_total", err_pulses - base, 1);

        // Loss of signal while locked.
        base = err_pulses;
        run_px(4, HT, 1'b0);
        run_px(0, HT, 1'b0);
        run_px(0, HT, 1'b0);
        pix(1'b1, 1'b1);
        found = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge PIXELCLK);
            if (o_err === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("los_err_seen", found, 1);
        chk("los_lock", int'(o_locked), 0);
        repeat (1500) @(negedge PIXELCLK);
        chk("los_err_once", err_pulses - base, 1);
        chk("los_hcnt_sat", int'(o_h_cnt), 1023);
        head("losA", 0, 0, 3, 2);
        chk("los_htot_sat", int'(o_h_total), 4095);
        frame_rest(VT, 4);
        head("losB", 0, 0, VT, VT - 1);
        frame_rest(VT, 4);
        head("losC", 0, 1, VT, VT - 1);
        chk("los_err_after", err_pulses - base, 1);

        // Asynchronous reset mid-frame while locked.
        base = err_pulses;
        run_px(4, HT, 1'b0);
        run_px(0, HT, 1'b0);
        run_px(0, 20, 1'b0);
        #2;
        i_rstn = 1'b0;
        VGA_HS = 1'b1;
        VGA_VS = 1'b1;
        #1;
        chk("mrst_hcnt", int'(o_h_cnt), 0);
        chk("mrst_vcnt", int'(o_v_cnt), 0);
        chk("mrst_htot", int'(o_h_total), 0);
        chk("mrst_hsw", int'(o_hs_width), 0);
        chk("mrst_vtot", int'(o_v_total), 0);
        chk("mrst_lock", int'(o_locked), 0);
        chk("mrst_err", int'(o_err), 0);
        repeat (3) @(negedge PIXELCLK);
        i_rstn = 1'b1;
        head("mrst0", 0, 0, 1, 0);
        frame_rest(VT, 4);
        head("mrst1", 0, 0, VT, VT - 1);
        frame_rest(VT, 4);
        head("mrst2", 0, 1, VT, VT - 1);
        chk("mrst_err_total", err_pulses - base, 0);

        // Wrong frame height (11 lines) never locks and never flags an error.
        @(negedge PIXELCLK);
        i_rstn = 1'b0;
        VGA_HS = 1'b1;
        VGA_VS = 1'b1;
        repeat (2) @(negedge PIXELCLK);
        i_rstn = 1'b1;
        base = err_pulses;
        head("wh0", 0, 0, 1, 0);
        frame_rest(VT - 1, 4);
        for (int k = 0; k < 4; k++) begin
            head("wh", 0, 0, VT - 1, VT - 2);
            frame_rest(VT - 1, 4);
        end
        chk("wh_lock", int'(o_locked), 0);
        chk("wh_err", err_pulses - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
